// File: rtl/rop_ba_cop.sv
// rop_ba_cop: bit/byte crypto co-processor with req/acc host handshake and its own memory port.
module rop_ba_cop #(
    parameter logic [6:0] OPCODE = 7'b0001011
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        clk_req,
    input  logic        cop_req,
    output logic        cop_acc,
    output logic        cop_rsp,
    input  logic [31:0] cop_instr_in,
    input  logic [31:0] cop_rs1,
    input  logic [31:0] cop_rs2,
    output logic [2:0]  cop_rd_byte,
    output logic [4:0]  cop_rd,
    output logic [31:0] cop_wdata,
    output logic        cop_wen,
    output logic        cop_mem_ld_error,
    output logic        cop_mem_st_error,
    output logic        cop_mem_cen,
    input  logic        cop_mem_stall,
    input  logic        cop_mem_error,
    output logic        cop_mem_wen,
    output logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_wdata,
    input  logic [31:0] cop_mem_rdata,
    output logic [31:0] cop_mem_addr
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;
    state_t state;
    logic        legal_q, mis_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [1:0]  lane_q, boff_q;
    logic [31:0] rs1_q, rs2_q;
    logic [2:0]  in_f3;
    logic [31:0] in_imm, in_addr, alu;
    logic        in_legal, in_mis, in_mem;
    logic [63:0] rot;
    logic        unused_ok;
    always_comb begin
        in_f3    = cop_instr_in[14:12];
        in_legal = cop_instr_in[6:0] == OPCODE;
        in_imm   = in_f3 == 3'd5 ? {{20{cop_instr_in[31]}}, cop_instr_in[31:25], cop_instr_in[11:7]}
                                 : {{20{cop_instr_in[31]}}, cop_instr_in[31:20]};
        in_addr  = cop_rs1 + in_imm;
        in_mis   = (in_f3 == 3'd4 || in_f3 == 3'd5) && in_addr[1:0] != 2'd0;
        in_mem   = in_legal && in_f3 >= 3'd4 && in_f3 <= 3'd6 && !in_mis;
        rot      = {rs1_q, rs1_q} >> rs2_q[4:0];
        alu      = f3_q == 3'd0 ? rs1_q + rs2_q :
                   f3_q == 3'd1 ? rs1_q ^ rs2_q :
                   f3_q == 3'd2 ? rot[31:0] :
                   f3_q == 3'd3 ? {4{rs1_q[7:0]}} : '0;
    end
    assign unused_ok = ^{cop_instr_in[19:15], rot[63:32]};
    // A response cycle already looks like IDLE, so acceptance waits one more cycle.
    assign cop_acc = resetn && cop_req && state == IDLE && !cop_rsp;
    assign clk_req = resetn && (cop_req || state != IDLE || cop_rsp);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            legal_q          <= 1'b0;
            mis_q            <= 1'b0;
            f3_q             <= '0;
            rd_q             <= '0;
            lane_q           <= '0;
            boff_q           <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            cop_rsp          <= 1'b0;
            cop_rd_byte      <= '0;
            cop_rd           <= '0;
            cop_wdata        <= '0;
            cop_wen          <= 1'b0;
            cop_mem_ld_error <= 1'b0;
            cop_mem_st_error <= 1'b0;
            cop_mem_cen      <= 1'b0;
            cop_mem_wen      <= 1'b0;
            cop_mem_ben      <= '0;
            cop_mem_wdata    <= '0;
            cop_mem_addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cop_rsp          <= 1'b0;
                    cop_wen          <= 1'b0;
                    cop_mem_ld_error <= 1'b0;
                    cop_mem_st_error <= 1'b0;
                    if (cop_acc) begin
                        legal_q       <= in_legal;
                        mis_q         <= in_legal && in_mis;
                        f3_q          <= in_f3;
                        rd_q          <= cop_instr_in[11:7];
                        lane_q        <= cop_instr_in[21:20];
                        boff_q        <= in_addr[1:0];
                        rs1_q         <= cop_rs1;
                        rs2_q         <= cop_rs2;
                        state         <= in_mem ? MEM : EXEC;
                        cop_mem_cen   <= in_mem;
                        cop_mem_wen   <= in_mem && in_f3 == 3'd5;
                        cop_mem_ben   <= !in_mem ? 4'h0 : in_f3 == 3'd6 ? 4'b0001 << in_addr[1:0] : 4'hF;
                        cop_mem_addr  <= in_f3 == 3'd6 ? {in_addr[31:2], 2'b00} : in_addr;
                        cop_mem_wdata <= cop_rs2;
                    end
                end
                EXEC: begin
                    state            <= IDLE;
                    cop_rsp          <= 1'b1;
                    cop_rd           <= rd_q;
                    cop_wen          <= legal_q && f3_q < 3'd4;
                    cop_wdata        <= legal_q ? alu : '0;
                    cop_rd_byte      <= legal_q && f3_q == 3'd3 ? {1'b0, lane_q} : 3'b100;
                    cop_mem_ld_error <= mis_q && f3_q == 3'd4;
                    cop_mem_st_error <= mis_q && f3_q == 3'd5;
                end
                MEM: begin
                    if (!cop_mem_stall) begin
                        state            <= IDLE;
                        cop_mem_cen      <= 1'b0;
                        cop_mem_wen      <= 1'b0;
                        cop_mem_ben      <= '0;
                        cop_rsp          <= 1'b1;
                        cop_rd           <= rd_q;
                        cop_rd_byte      <= 3'b100;
                        cop_wen          <= !cop_mem_error && f3_q != 3'd5;
                        cop_mem_ld_error <= cop_mem_error && f3_q != 3'd5;
                        cop_mem_st_error <= cop_mem_error && f3_q == 3'd5;
                        cop_wdata        <= f3_q == 3'd6 ? {24'd0, cop_mem_rdata[{boff_q, 3'b000} +: 8]} :
                                            f3_q == 3'd4 ? cop_mem_rdata : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rop_ba_cop.sv
// tb_rop_ba_cop: directed stimulus with a response scoreboard for rop_ba_cop.
module tb_rop_ba_cop;
    logic        clk = 1'b0, resetn = 1'b0, cop_req = 1'b0;
    logic        cop_mem_stall = 1'b1, cop_mem_error = 1'b0;
    logic [31:0] cop_instr_in = '0, cop_rs1 = '0, cop_rs2 = '0, cop_mem_rdata = '0;
    logic        clk_req, cop_acc, cop_rsp, cop_wen, cop_mem_ld_error, cop_mem_st_error;
    logic        cop_mem_cen, cop_mem_wen;
    logic [2:0]  cop_rd_byte;
    logic [4:0]  cop_rd;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_wdata, cop_mem_wdata, cop_mem_addr;

    rop_ba_cop dut (
        .clk(clk), .resetn(resetn), .clk_req(clk_req), .cop_req(cop_req), .cop_acc(cop_acc),
        .cop_rsp(cop_rsp), .cop_instr_in(cop_instr_in), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_rd_byte(cop_rd_byte), .cop_rd(cop_rd), .cop_wdata(cop_wdata), .cop_wen(cop_wen),
        .cop_mem_ld_error(cop_mem_ld_error), .cop_mem_st_error(cop_mem_st_error),
        .cop_mem_cen(cop_mem_cen), .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
        .cop_mem_wen(cop_mem_wen), .cop_mem_ben(cop_mem_ben), .cop_mem_wdata(cop_mem_wdata),
        .cop_mem_rdata(cop_mem_rdata), .cop_mem_addr(cop_mem_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] wdata;
        logic        wen;
        logic [4:0]  rd;
        logic [2:0]  rd_byte;
        logic        ld;
        logic        st;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t e;
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t r(input logic [31:0] w, input logic we, input logic [4:0] rd,
                               input logic [2:0] rb, input logic ld, input logic st);
        return '{w, we, rd, rb, ld, st};
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, f3, rd, 7'b0001011};
    endfunction

    always @(negedge clk) begin
        if (cop_rsp === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_rsp observed=rsp rd=%0d expected=no response", cop_rd);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_ctl", 64'({cop_wen, cop_rd, cop_mem_ld_error, cop_mem_st_error}),
                    64'({e.wen, e.rd, e.ld, e.st}));
                if (e.wen) begin
                    chk("rsp_wdata", 64'(cop_wdata), 64'(e.wdata));
                    chk("rsp_rd_byte", 64'(cop_rd_byte), 64'(e.rd_byte));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        int n = 0;
        cop_instr_in = instr;
        cop_rs1 = rs1;
        cop_rs2 = rs2;
        cop_req = 1'b1;
        #1;
        while (cop_acc !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("acc_seen", 64'(cop_acc), 64'd1);
        @(posedge clk);
        #1;
        cop_req = 1'b0;
        chk("acc_drop", 64'(cop_acc), 64'd0);
    endtask

    task automatic mem_serve(input logic [31:0] addr, input logic wen, input logic [3:0] ben,
                             input int stalls, input logic [31:0] rdata, input logic err);
        int n = 0;
        while (cop_mem_cen !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_cen", 64'(cop_mem_cen), 64'd1);
        for (int i = 0; i < stalls; i++) begin
            chk("mem_req_stall", 64'({cop_mem_addr, cop_mem_wen, cop_mem_ben}), 64'({addr, wen, ben}));
            @(posedge clk);
            #1;
        end
        chk("mem_req", 64'({cop_mem_cen, cop_mem_addr, cop_mem_wen, cop_mem_ben}), 64'({1'b1, addr, wen, ben}));
        cop_mem_stall = 1'b0;
        cop_mem_rdata = rdata;
        cop_mem_error = err;
        @(posedge clk);
        #1;
        cop_mem_stall = 1'b1;
        cop_mem_rdata = '0;
        cop_mem_error = 1'b0;
        chk("mem_idle", 64'({cop_mem_cen, cop_mem_wen, cop_mem_ben}), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset_ctl", 64'({clk_req, cop_acc, cop_rsp, cop_wen, cop_mem_ld_error, cop_mem_st_error,
                              cop_mem_cen, cop_mem_wen, cop_mem_ben, cop_rd, cop_rd_byte}), 64'd0);
        chk("reset_data", 64'({cop_wdata, cop_mem_addr}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("clk_req_idle", 64'(clk_req), 64'd0);
        cop_req = 1'b1;
        #1;
        chk("clk_req_wake", 64'(clk_req), 64'd1);

        exp_q.push_back(r(32'h00000001, 1'b1, 5'd5, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd0, 5'd5, 12'd0), 32'hFFFFFFFF, 32'd2);
        chk("add_rsp_early", 64'(cop_rsp), 64'd0);
        @(posedge clk);
        #1;
        chk("add_latency", 64'(cop_rsp), 64'd1);
        drain();

        exp_q.push_back(r(32'h5A5A0FF0, 1'b1, 5'd4, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd1, 5'd4, 12'd0), 32'hFFFF00FF, 32'hA5A50F0F);
        drain();

        exp_q.push_back(r(32'hC0000000, 1'b1, 5'd6, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd2, 5'd6, 12'd0), 32'h80000001, 32'h00000021);
        drain();

        exp_q.push_back(r(32'h12345678, 1'b1, 5'd6, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd2, 5'd6, 12'd0), 32'h12345678, 32'h00000020);
        drain();

        exp_q.push_back(r(32'hABABABAB, 1'b1, 5'd9, 3'b010, 1'b0, 1'b0));
        issue(mk(3'd3, 5'd9, 12'h002), 32'h000000AB, 32'd0);
        drain();

        exp_q.push_back(r(32'hDEADBEEF, 1'b1, 5'd7, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd4, 5'd7, 12'd4), 32'h00001000, 32'd0);
        mem_serve(32'h00001004, 1'b0, 4'hF, 3, 32'hDEADBEEF, 1'b0);
        drain();

        exp_q.push_back(r(32'h0, 1'b0, 5'd7, 3'b100, 1'b1, 1'b0));
        issue(mk(3'd4, 5'd7, 12'd4), 32'h00001000, 32'd0);
        mem_serve(32'h00001004, 1'b0, 4'hF, 3, 32'hDEADBEEF, 1'b1);
        drain();

        exp_q.push_back(r(32'h0, 1'b0, 5'd0, 3'b100, 1'b0, 1'b1));
        issue(mk(3'd5, 5'd0, 12'd0), 32'h00002002, 32'h11111111);
        chk("sw_mis_nocen", 64'(cop_mem_cen), 64'd0);
        @(posedge clk);
        #1;
        chk("sw_mis_nocen_rsp", 64'({cop_mem_cen, cop_rsp}), 64'b01);
        drain();

        exp_q.push_back(r(32'h0000007F, 1'b1, 5'd8, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd6, 5'd8, 12'd3), 32'h00001000, 32'd0);
        mem_serve(32'h00001000, 1'b0, 4'b1000, 1, 32'h7F000000, 1'b0);
        drain();

        exp_q.push_back(r(32'h0, 1'b0, 5'd8, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd5, 5'd8, 12'd0), 32'h00003000, 32'h12345678);
        chk("sw_wdata", 64'(cop_mem_wdata), 64'h12345678);
        mem_serve(32'h00003008, 1'b1, 4'hF, 1, 32'd0, 1'b0);
        drain();

        exp_q.push_back(r(32'h00000FF0, 1'b1, 5'd1, 3'b100, 1'b0, 1'b0));
        exp_q.push_back(r(32'h0, 1'b0, 5'd3, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd1, 5'd1, 12'd0), 32'h00000F0F, 32'h000000FF);
        cop_instr_in = 32'h000001B3;
        cop_req = 1'b1;
        chk("b2b_exec_noacc", 64'(cop_acc), 64'd0);
        @(posedge clk);
        #1;
        chk("b2b_rsp_noacc", 64'({cop_acc, cop_rsp}), 64'b01);
        @(posedge clk);
        #1;
        chk("b2b_acc_after_rsp", 64'({cop_acc, cop_rsp}), 64'b10);
        issue(32'h000001B3, 32'd1, 32'd2);
        drain();

        issue(mk(3'd4, 5'd7, 12'd4), 32'h00001000, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mem_cen", 64'(cop_mem_cen), 64'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_drop", 64'({cop_mem_cen, cop_rsp, cop_acc, clk_req}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_idle", 64'({cop_mem_cen, cop_rsp}), 64'd0);

        exp_q.push_back(r(32'h00000030, 1'b1, 5'd2, 3'b100, 1'b0, 1'b0));
        issue(mk(3'd0, 5'd2, 12'd0), 32'h10, 32'h20);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rop_ba_cop.md
Name: rop_ba_cop

Overview:
- Small bit/byte-oriented crypto co-processor attached to a RISC-V host core.
- Accepts one instruction at a time over a req/acc handshake, with two host source operands.
- Returns a register writeback (word or single byte lane) over a response strobe.
- Has its own 32-bit memory port for loads and stores, and requests its own (gated) clock.

Parameters:
- OPCODE, 7'b0001011, major opcode (instr[6:0]) the block executes; any other opcode is illegal.

Ports:
- clk  in  1  clock; gated externally by clk_req.
- resetn  in  1  reset; asynchronous, active-low.
- clk_req  out  1  clock request.
- cop_req  in  1  instruction request valid.
- cop_acc  out  1  request accepted.
- cop_rsp  out  1  response valid (one-cycle pulse).
- cop_instr_in  in  32  instruction word.
- cop_rs1  in  32  source operand 1.
- cop_rs2  in  32  source operand 2.
- cop_rd_byte  out  3  write mode: 3'b100 = full word; 3'b0bb = byte lane bb only.
- cop_rd  out  5  destination host register (instr[11:7]).
- cop_wdata  out  32  writeback data.
- cop_wen  out  1  writeback enable, qualified by cop_rsp.
- cop_mem_ld_error  out  1  load failed, qualified by cop_rsp.
- cop_mem_st_error  out  1  store failed, qualified by cop_rsp.
- cop_mem_cen  out  1  memory request.
- cop_mem_stall  in  1  memory not ready.
- cop_mem_error  in  1  bus error, valid on the completing cycle.
- cop_mem_wen  out  1  1 = store.
- cop_mem_ben  out  4  byte enables.
- cop_mem_wdata  out  32  store data.
- cop_mem_rdata  in  32  load data, valid on the completing cycle.
- cop_mem_addr  out  32  byte address.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE.
- clk_req = cop_req | (state != IDLE) | cop_rsp. It is combinational so a request can wake the clock.
- FSM states:
  - IDLE: when cop_req=1, cop_acc=1 combinationally for that cycle; instr/rs1/rs2 are latched. Next state is EXEC (ALU/illegal ops) or MEM (memory ops). The host holds cop_req and inputs until acc.
  - EXEC: drive the response for one cycle (cop_rsp=1), then IDLE. ALU latency is 2 cycles from acc to rsp.
  - MEM: cop_mem_cen=1, with addr/wen/ben/wdata held stable while cop_mem_stall=1. The transfer completes on the cycle cen=1 and stall=0; rdata and error are sampled then. The response is the next cycle, then IDLE.
- cop_acc is never asserted outside IDLE. A cop_req arriving in the cycle cop_rsp is high is accepted in the following IDLE cycle.
- Decode uses funct3 = instr[14:12]; imm = sext(instr[31:20]); simm = sext({instr[31:25], instr[11:7]}).
  - 0 ADD: wdata = rs1 + rs2, mod 2^32; word write.
  - 1 XOR: rs1 ^ rs2; word write.
  - 2 ROTR: rotate rs1 right by rs2[4:0]; a shift of 0 passes rs1 unchanged.
  - 3 BINS: cop_rd_byte = {1'b0, instr[21:20]}; wdata = {4{rs1[7:0]}}.
  - 4 LW: addr = rs1 + imm. If addr[1:0] != 0, there is no memory access: rsp with ld_error=1, wen=0. Otherwise ben = 4'hF and wdata = rdata.
  - 5 SW: addr = rs1 + simm; must be word-aligned (misaligned gives st_error, no access). wen=1, ben=4'hF, mem_wdata = rs2. Never writes back.
  - 6 LB: addr = rs1 + imm, any alignment. Read at the word address (addr[1:0] cleared) with ben = one-hot of addr[1:0]. wdata = zero-extended selected byte.
  - 7, or opcode != OPCODE: rsp with wen=0 and no errors.
- cop_mem_error=1 on completion:
  - ld_error=1 (loads) or st_error=1 (stores), with wen=0.
- cop_wen=1 on rsp only for ops 0-4 and 6 without error.
- cop_rd = instr[11:7] on every response. Writes to rd=0 are still reported; the host discards them.
- cop_rd_byte = 3'b100 for all word results, including LB.
- When cop_rsp=0: wen, ld_error and st_error are all 0.
- When cen=0: mem_wen=0 and mem_ben=0.
- Asynchronous reset mid-operation: cen, rsp and acc drop immediately. The in-flight instruction is abandoned with no response.

Test Plan:
- ADD: rs1=0xFFFFFFFF, rs2=2, rd=5 -> acc 1 cycle; rsp 2 cycles after acc; wdata=0x00000001, wen=1, cop_rd=5, rd_byte=3'b100.
- ROTR: rs1=0x80000001, rs2=0x21 -> wdata=0xC0000000.
- BINS: rs1=0xAB, instr[21:20]=2 -> rd_byte=3'b010, wdata=0xABABABAB.
- LW with 3 stall cycles, rs1=0x1000, imm=4:
  - addr=0x1004 held throughout, ben=F.
  - rdata=0xDEADBEEF -> rsp next cycle with wdata=0xDEADBEEF.
  - Repeat with cop_mem_error=1 -> ld_error=1, wen=0.
- SW rs1=0x2002 (misaligned), and LB addr 0x1003:
  - SW -> no cen, st_error=1.
  - LB -> addr=0x1000, ben=4'b1000; rdata=0x7F000000 -> wdata=0x7F.
- Back-to-back requests, an illegal opcode, and reset mid-MEM:
  - Second acc only after the first rsp.
  - Illegal op -> rsp with wen=0.
  - resetn low mid-MEM -> cen=0 immediately, no rsp.
